// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencer: FSM states, opcodes,
// datapath mux encodings and the control vector driven into the datapath.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_SEXT    = 2'b10;
    localparam logic [1:0] SRCB_SEXT_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctrl_t;

    function automatic logic op_is_legal(input logic [5:0] op);
        logic legal;
        case (op)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: legal = 1'b1;
            default:                                   legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational control-vector decode for the multi-cycle sequencer. Mostly
// Moore on state; FETCH strobes and the MEM_WRITE retire pulse follow mem_ready.
module mc_output_decode
    import mc_ctrl_pkg::*;
(
    input  state_e state_i,
    input  logic   mem_ready_i,
    input  logic   rst_i,
    output ctrl_t  ctrl_o
);

    ctrl_t raw_s;

    // Per-state control values; anything not set stays 0.
    always_comb begin
        raw_s = '0;
        case (state_i)
            S_FETCH: begin
                raw_s.mem_read  = 1'b1;
                raw_s.alu_src_b = SRCB_FOUR;
                raw_s.alu_op    = ALUOP_ADD;
                raw_s.pc_source = PCSRC_ALU;
                raw_s.ir_write  = mem_ready_i;
                raw_s.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                raw_s.alu_src_b = SRCB_SEXT_SH;
                raw_s.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR: begin
                raw_s.alu_src_a = 1'b1;
                raw_s.alu_src_b = SRCB_SEXT;
                raw_s.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                raw_s.iord     = 1'b1;
                raw_s.mem_read = 1'b1;
            end
            S_MEM_WB: begin
                raw_s.mem_to_reg = 1'b1;
                raw_s.reg_write  = 1'b1;
                raw_s.instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                raw_s.iord       = 1'b1;
                raw_s.mem_write  = 1'b1;
                raw_s.instr_done = mem_ready_i;
            end
            S_R_EXEC: begin
                raw_s.alu_src_a = 1'b1;
                raw_s.alu_src_b = SRCB_B;
                raw_s.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                raw_s.reg_dst    = 1'b1;
                raw_s.reg_write  = 1'b1;
                raw_s.instr_done = 1'b1;
            end
            S_BRANCH: begin
                raw_s.alu_src_a     = 1'b1;
                raw_s.alu_src_b     = SRCB_B;
                raw_s.alu_op        = ALUOP_SUB;
                raw_s.pc_source     = PCSRC_ALUOUT;
                raw_s.pc_write_cond = 1'b1;
                raw_s.instr_done    = 1'b1;
            end
            S_JUMP: begin
                raw_s.pc_source  = PCSRC_JUMP;
                raw_s.pc_write   = 1'b1;
                raw_s.instr_done = 1'b1;
            end
            S_ADDI_EXEC: begin
                raw_s.alu_src_a = 1'b1;
                raw_s.alu_src_b = SRCB_SEXT;
                raw_s.alu_op    = ALUOP_ADD;
            end
            S_ADDI_WB: begin
                raw_s.reg_write  = 1'b1;
                raw_s.instr_done = 1'b1;
            end
            default: raw_s = '0;
        endcase
    end

    // Reset suppresses every architectural write strobe; mux selects pass through.
    assign ctrl_o.pc_write      = raw_s.pc_write      & ~rst_i;
    assign ctrl_o.pc_write_cond = raw_s.pc_write_cond & ~rst_i;
    assign ctrl_o.ir_write      = raw_s.ir_write      & ~rst_i;
    assign ctrl_o.mem_write     = raw_s.mem_write     & ~rst_i;
    assign ctrl_o.reg_write     = raw_s.reg_write     & ~rst_i;
    assign ctrl_o.instr_done    = raw_s.instr_done    & ~rst_i;
    assign ctrl_o.iord          = raw_s.iord;
    assign ctrl_o.mem_read      = raw_s.mem_read;
    assign ctrl_o.mem_to_reg    = raw_s.mem_to_reg;
    assign ctrl_o.reg_dst       = raw_s.reg_dst;
    assign ctrl_o.alu_src_a     = raw_s.alu_src_a;
    assign ctrl_o.alu_src_b     = raw_s.alu_src_b;
    assign ctrl_o.alu_op        = raw_s.alu_op;
    assign ctrl_o.pc_source     = raw_s.pc_source;

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control unit: state register, next-state dispatch and the
// retired-instruction counter; control decode lives in mc_output_decode.
module mc_control_unit
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        RegDst,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic [1:0]  PCSource,
    output logic [3:0]  state,
    output logic        instr_done,
    output logic        illegal_op,
    output logic [31:0] instr_count
);

    state_e      state_q;
    logic [31:0] instr_count_q;
    logic [31:0] instr_count_d;
    ctrl_t       ctrl_s;
    logic        zero_unused_s;

    mc_output_decode u_decode (
        .state_i     (state_q),
        .mem_ready_i (mem_ready),
        .rst_i       (rst),
        .ctrl_o      (ctrl_s)
    );

    // zero is consumed by the datapath's PC-load gate, not by the sequencer.
    assign zero_unused_s = zero;

    // Counter wraps naturally through the 32-bit add.
    always_comb begin
        instr_count_d = instr_count_q;
        if (ctrl_s.instr_done) begin
            instr_count_d = instr_count_q + 32'd1;
        end else begin
            instr_count_d = instr_count_q;
        end
    end

    // Sequencer state and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_FETCH;
            instr_count_q <= 32'd0;
        end else begin
            instr_count_q <= instr_count_d;
            case (state_q)
                S_FETCH:     state_q <= mem_ready ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (opcode)
                        OP_R:         state_q <= S_R_EXEC;
                        OP_LW, OP_SW: state_q <= S_MEM_ADDR;
                        OP_BEQ:       state_q <= S_BRANCH;
                        OP_J:         state_q <= S_JUMP;
                        OP_ADDI:      state_q <= S_ADDI_EXEC;
                        default:      state_q <= S_FETCH;
                    endcase
                end
                S_MEM_ADDR:  state_q <= (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
                S_MEM_READ:  state_q <= mem_ready ? S_MEM_WB : S_MEM_READ;
                S_MEM_WB:    state_q <= S_FETCH;
                S_MEM_WRITE: state_q <= mem_ready ? S_FETCH : S_MEM_WRITE;
                S_R_EXEC:    state_q <= S_R_WB;
                S_R_WB:      state_q <= S_FETCH;
                S_BRANCH:    state_q <= S_FETCH;
                S_JUMP:      state_q <= S_FETCH;
                S_ADDI_EXEC: state_q <= S_ADDI_WB;
                S_ADDI_WB:   state_q <= S_FETCH;
                default:     state_q <= S_FETCH;
            endcase
        end
    end

    assign illegal_op  = (state_q == S_DECODE) & ~op_is_legal(opcode) & ~rst;

    assign PCWrite     = ctrl_s.pc_write;
    assign PCWriteCond = ctrl_s.pc_write_cond;
    assign IorD        = ctrl_s.iord;
    assign MemRead     = ctrl_s.mem_read;
    assign MemWrite    = ctrl_s.mem_write;
    assign MemtoReg    = ctrl_s.mem_to_reg;
    assign IRWrite     = ctrl_s.ir_write;
    assign RegWrite    = ctrl_s.reg_write;
    assign RegDst      = ctrl_s.reg_dst;
    assign ALUSrcA     = ctrl_s.alu_src_a;
    assign ALUSrcB     = ctrl_s.alu_src_b;
    assign ALUOp       = ctrl_s.alu_op;
    assign PCSource    = ctrl_s.pc_source;
    assign instr_done  = ctrl_s.instr_done;
    assign state       = state_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: a per-instruction plan model predicts
// the state trace and strobe totals; a negedge monitor compares at each retire.
module tb_mc_control_unit;

    logic        clk = 1'b0;
    logic        rst, zero, mem_ready;
    logic [5:0]  opcode;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic        IRWrite, RegWrite, RegDst, ALUSrcA;
    logic [1:0]  ALUSrcB, ALUOp, PCSource;
    logic [3:0]  state;
    logic        instr_done, illegal_op;
    logic [31:0] instr_count;

    mc_control_unit dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .state(state), .instr_done(instr_done),
        .illegal_op(illegal_op), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        illegal;
        logic [4:0]  len;
        logic [63:0] trace;
        logic [4:0]  n_mr, n_mw, n_rw, n_rw_m2r, n_rw_dst;
        logic [4:0]  n_pcw_fetch, n_pcw_jump, n_pcwc01;
        logic [31:0] count_before;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b0;
    logic [31:0] model_count = 32'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: accumulate one instruction's activity, compare on retire/illegal.
    initial begin
        exp_t        a, e;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                a = '0;
            end else begin
                if (a.len < 5'd16) a.trace = a.trace | (64'(state) << (4 * a.len));
                a.len         = a.len + 5'd1;
                a.n_mr        = a.n_mr + 5'(MemRead);
                a.n_mw        = a.n_mw + 5'(MemWrite);
                a.n_rw        = a.n_rw + 5'(RegWrite);
                a.n_rw_m2r    = a.n_rw_m2r + 5'(RegWrite & MemtoReg);
                a.n_rw_dst    = a.n_rw_dst + 5'(RegWrite & RegDst);
                a.n_pcw_fetch = a.n_pcw_fetch + 5'(PCWrite & IRWrite & (PCSource == 2'b00));
                a.n_pcw_jump  = a.n_pcw_jump + 5'(PCWrite & ~IRWrite & (PCSource == 2'b10));
                a.n_pcwc01    = a.n_pcwc01 + 5'(PCWriteCond & (PCSource == 2'b01));
                if (instr_done || illegal_op) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_retire", 64'(state), 64'hF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("illegal_flag", 64'(illegal_op), 64'(e.illegal));
                        chk("done_flag", 64'(instr_done), 64'(!e.illegal));
                        chk("latency", 64'(a.len), 64'(e.len));
                        chk("state_trace", a.trace, e.trace);
                        chk("memread_cycles", 64'(a.n_mr), 64'(e.n_mr));
                        chk("memwrite_cycles", 64'(a.n_mw), 64'(e.n_mw));
                        chk("regwrite_cycles", 64'(a.n_rw), 64'(e.n_rw));
                        chk("regwrite_memtoreg", 64'(a.n_rw_m2r), 64'(e.n_rw_m2r));
                        chk("regwrite_regdst", 64'(a.n_rw_dst), 64'(e.n_rw_dst));
                        chk("fetch_pcwrite", 64'(a.n_pcw_fetch), 64'(e.n_pcw_fetch));
                        chk("jump_pcwrite", 64'(a.n_pcw_jump), 64'(e.n_pcw_jump));
                        chk("branch_pcwritecond", 64'(a.n_pcwc01), 64'(e.n_pcwc01));
                        chk("count_at_retire", 64'(instr_count), 64'(e.count_before));
                    end
                    a = '0;
                end
            end
        end
    end

    // Plan one instruction from the ISA rules, push its expectation, drive it.
    task automatic run_instr(input logic [5:0] op, input int fst, input int mst,
                             input logic z, input logic force_max);
        logic [3:0] st[$];
        logic       mr[$];
        exp_t       e;
        logic       legal;
        e = '0;
        for (int i = 0; i < fst; i++) begin st.push_back(4'd0); mr.push_back(1'b0); end
        st.push_back(4'd0); mr.push_back(1'b1);
        st.push_back(4'd1); mr.push_back(1'($urandom));
        legal = 1'b1;
        case (op)
            6'b000000: begin st.push_back(4'd6); st.push_back(4'd7); e.n_rw = 5'd1; e.n_rw_dst = 5'd1; end
            6'b100011: begin
                st.push_back(4'd2); mr.push_back(1'($urandom));
                for (int i = 0; i < mst; i++) begin st.push_back(4'd3); mr.push_back(1'b0); end
                st.push_back(4'd3); mr.push_back(1'b1);
                st.push_back(4'd4);
                e.n_mr = 5'(mst + 1); e.n_rw = 5'd1; e.n_rw_m2r = 5'd1;
            end
            6'b101011: begin
                st.push_back(4'd2); mr.push_back(1'($urandom));
                for (int i = 0; i < mst; i++) begin st.push_back(4'd5); mr.push_back(1'b0); end
                st.push_back(4'd5); mr.push_back(1'b1);
                e.n_mw = 5'(mst + 1);
            end
            6'b000100: begin st.push_back(4'd8); e.n_pcwc01 = 5'd1; end
            6'b000010: begin st.push_back(4'd9); e.n_pcw_jump = 5'd1; end
            6'b001000: begin st.push_back(4'd10); st.push_back(4'd11); e.n_rw = 5'd1; end
            default:   legal = 1'b0;
        endcase
        while (mr.size() < st.size()) mr.push_back(1'($urandom));
        if (force_max) model_count = 32'hFFFF_FFFF;
        e.illegal      = !legal;
        e.len          = 5'(st.size());
        e.n_mr         = e.n_mr + 5'(fst + 1);
        e.n_pcw_fetch  = 5'd1;
        e.count_before = model_count;
        for (int i = 0; i < st.size(); i++) e.trace = e.trace | (64'(st[i]) << (4 * i));
        exp_q.push_back(e);
        if (legal) model_count = model_count + 32'd1;
        for (int c = 0; c < st.size(); c++) begin
            opcode    = (st[c] == 4'd1 || st[c] == 4'd2) ? op : 6'($urandom);
            mem_ready = mr[c];
            zero      = z;
            if (c == 0 && force_max) begin
                force dut.instr_count_q = 32'hFFFF_FFFF;
                #1;
                release dut.instr_count_q;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [5:0] ops[7];
        int         waited;
        ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011; ops[3] = 6'b000100;
        ops[4] = 6'b000010; ops[5] = 6'b001000; ops[6] = 6'b111111;

        rst = 1'b1; mem_ready = 1'b1; opcode = 6'b000000; zero = 1'b0;
        @(posedge clk); #1;
        chk("reset_state", 64'(state), 64'd0);
        chk("reset_count", 64'(instr_count), 64'd0);
        chk("reset_strobes", 64'({PCWrite, PCWriteCond, IRWrite, MemWrite, RegWrite, instr_done, illegal_op}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; mon_en = 1'b1; model_count = 32'd0;

        run_instr(6'b000000, 0, 0, 1'b0, 1'b0);
        run_instr(6'b100011, 0, 3, 1'b0, 1'b0);
        run_instr(6'b101011, 0, 0, 1'b0, 1'b0);
        run_instr(6'b000100, 0, 0, 1'b1, 1'b0);
        run_instr(6'b000100, 0, 0, 1'b0, 1'b0);
        run_instr(6'b111111, 0, 0, 1'b0, 1'b0);
        run_instr(6'b001000, 1, 0, 1'b0, 1'b0);
        run_instr(6'b000010, 2, 0, 1'b1, 1'b0);
        for (int n = 0; n < 40; n++) begin
            run_instr(ops[$urandom_range(0, 6)], $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom), 1'b0);
        end

        // Abandon a stalled lw in MEM_READ with reset.
        mon_en = 1'b0;
        opcode = 6'b100011; mem_ready = 1'b1;
        waited = 0;
        while (state != 4'd3 && waited < 10) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("reach_mem_read", 64'(state), 64'd3);
        mem_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; mem_ready = 1'b1;
        #2;
        chk("rst_midinstr_strobes", 64'({PCWrite, PCWriteCond, IRWrite, MemWrite, RegWrite, instr_done, illegal_op}), 64'd0);
        @(posedge clk); #1;
        chk("rst_midinstr_state", 64'(state), 64'd0);
        chk("rst_midinstr_count", 64'(instr_count), 64'd0);
        rst = 1'b0; model_count = 32'd0;
        #2;
        chk("post_rst_regwrite", 64'(RegWrite), 64'd0);
        #2;
        mon_en = 1'b1;

        run_instr(6'b000010, 0, 0, 1'b0, 1'b1);
        run_instr(6'b000000, 0, 0, 1'b0, 1'b0);
        run_instr(6'b101011, 1, 2, 1'b0, 1'b0);

        @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        chk("final_count", 64'(instr_count), 64'(model_count));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multi-cycle sequencer for the MIPS datapath: replaces the single-cycle control decoder with a Moore FSM that steps each instruction through fetch, decode, execute, memory and write-back. It drives the datapath's mux selects and write strobes, shares one memory port between instruction fetch and data access, and stalls on a memory-ready handshake. It sits between the instruction register opcode field and the PC/register-file/ALU/memory enables inside `cpu`.

## Interface
- No parameters.
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `opcode`  in  6  IR[31:26], valid from DECODE onward
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  shared memory completes the current access this cycle
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `MemtoReg`, `IRWrite`, `RegWrite`, `RegDst`, `ALUSrcA`  out  1 each  datapath controls
- `ALUSrcB`  out  2  00 = B, 01 = const 4, 10 = sign-ext, 11 = sign-ext<<2
- `ALUOp`  out  2  00 = add, 01 = sub, 10 = funct field
- `PCSource`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- `state`  out  4  current state, for debug
- `instr_done`  out  1  one-cycle pulse on the last cycle of each retired instruction
- `illegal_op`  out  1  one-cycle pulse in DECODE on an unsupported opcode
- `instr_count`  out  32  retired-instruction counter

## Operation
- States (4-bit): FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11.
- FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. Hold while mem_ready=0. When mem_ready=1, assert IRWrite and PCWrite and go to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Dispatch on opcode:
  - 000000 → R_EXEC
  - 100011 or 101011 → MEM_ADDR
  - 000100 → BRANCH
  - 000010 → JUMP
  - 001000 → ADDI_EXEC
  - anything else → FETCH, with illegal_op=1. The instruction is not counted.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: IorD=1, MemRead=1. Hold until mem_ready, then go to MEM_WB.
- MEM_WB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1, then FETCH.
- MEM_WRITE: IorD=1, MemWrite=1 for every cycle held. Hold until mem_ready; instr_done=1 in the mem_ready cycle, then FETCH.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10, then R_WB.
- R_WB: RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1, then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, PCWriteCond=1, instr_done=1, then FETCH. The datapath computes PC load as PCWrite | (PCWriteCond & zero).
- JUMP: PCSource=10, PCWrite=1, instr_done=1, then FETCH.
- ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00, then ADDI_WB.
- ADDI_WB: RegDst=0, MemtoReg=0, RegWrite=1, instr_done=1, then FETCH.
- Every control not listed for a state is 0.
- instr_count increments by 1 on each instr_done and wraps from 0xFFFFFFFF to 0.

## Timing
- Outputs are Moore, decoded from `state`. The exceptions are IRWrite/PCWrite in FETCH and instr_done in MEM_WRITE, which are additionally gated by mem_ready (Mealy).
- Reset: state=FETCH and instr_count=0 on the first clk edge with rst=1.
  - While rst=1, these strobes are forced to 0: PCWrite, PCWriteCond, IRWrite, MemWrite, RegWrite, instr_done, illegal_op.
  - Reset mid-instruction abandons it immediately; nothing is written.
- Latency with mem_ready tied high:
  - lw 5 cycles
  - sw, R-type, addi 4 cycles
  - beq, j 3 cycles
  - illegal opcode 2 cycles
- Each mem_ready=0 cycle in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- mem_ready is ignored in every other state.
- The opcode is sampled only in DECODE and MEM_ADDR. Changes to opcode at other times have no effect.

## Structure
- Package `mc_ctrl_pkg` holds:
  - state encodings
  - opcode constants (R, LW, SW, BEQ, J, ADDI)
  - ALUOp, ALUSrcB and PCSource encodings
- Sub-module `mc_output_decode` is combinational: state + mem_ready + rst → control vector. The FSM register, next-state logic and counter stay in `mc_control_unit`.

## Test plan
- rst held 2 cycles, then released with mem_ready=1 and opcode=000000 → state sequence 0,1,6,7,0; RegWrite=1 and RegDst=1 only in state 7; instr_count=1.
- lw (100011) with mem_ready low for 3 cycles in MEM_READ → MemRead=1 and IorD=1 held 4 cycles; total 8 cycles; exactly one RegWrite with MemtoReg=1.
- sw (101011) with mem_ready=1 → states 0,1,2,5,0; MemWrite=1 for exactly 1 cycle; RegWrite never asserted.
- beq with zero=1, then beq with zero=0 → PCWriteCond=1 and PCSource=01 in state 8 both times; 3 cycles each; instr_count +2.
- opcode=111111 → illegal_op pulse in DECODE, next state FETCH, instr_count unchanged. Separately: rst asserted while in MEM_READ → state=0 next cycle, no RegWrite.
- Counter wrap: force instr_count to 0xFFFFFFFF, retire a j → instr_count=0; PCWrite=1 and PCSource=10 in state 9.
